seq_instr_loader: RTL
=====================

// Module: seq_instr_loader
// PURPOSE
//  Streams instruction records {row, col, instr} from a testbench/boot source into the
//  sequencer instruction memories of the DRRA fabric. It is the writer counterpart of the
//  sequencer activity monitor: it drives instr_ld/instr_inp/seq_address_rb/cb, and the
//  monitor later decodes those instructions per cell.
//  One loader per fabric; sits between the program source (valid/ready) and all sequencers.
// PARAMETERS
//  ROWS         2   fabric rows (from shared package)
//  COLUMNS      8   fabric columns (from shared package)
//  INSTR_WIDTH  27  instruction word width
//  INSTR_DEPTH  64  sequencer instruction memory depth per cell
// PORTS
//  clk             in   1            clock, all logic on rising edge
//  rst             in   1            synchronous reset, active-high
//  start           in   1            begin a load session (sampled in IDLE only)
//  in_valid        in   1            record valid
//  in_ready        out  1            loader accepts record this cycle
//  in_row          in   $clog2(ROWS) target row
//  in_col          in   $clog2(COLUMNS) target column
//  in_instr        in   INSTR_WIDTH  instruction word
//  in_last         in   1            final record of session
//  instr_ld        out  1            instruction write strobe to sequencers
//  instr_inp       out  INSTR_WIDTH  instruction word to sequencers
//  seq_address_rb  out  ROWS         one-hot row select
//  seq_address_cb  out  COLUMNS      one-hot column select
//  done            out  1            one-cycle pulse: session complete
//  err_addr        out  1            sticky: record with out-of-range row/col dropped
//  err_ovf         out  1            sticky: cell overflow (only with macro, else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; per-cell counts and sticky errors cleared.
//    Reset mid-session aborts; no further instr_ld; the partial load is not completed.
//  - FSM: IDLE --start--> LOAD --accept with in_last--> FLUSH --> DONE --> IDLE.
//  - in_ready=1 only in LOAD. Accept = in_valid & in_ready.
//  - Latency 1: an accepted record appears on instr_ld/instr_inp/rb/cb the next cycle,
//    registered; instr_ld high exactly one cycle per valid record; back-to-back accepts give
//    continuous instr_ld. When instr_ld=0, instr_inp/rb/cb are 0.
//  - FLUSH: emits the last record's strobe; DONE: done=1 for one cycle; then IDLE.
//  - Out-of-range row (>=ROWS) or col (>=COLUMNS): record consumed, no instr_ld, err_addr=1.
//  - in_last on a dropped record still ends the session.
//  - start outside IDLE is ignored; start and in_valid together in IDLE: no accept that
//    cycle (in_ready=0 in IDLE).
//  - Per-cell counter (log2(INSTR_DEPTH)+1 bits) increments on each emitted strobe and is
//    cleared on entry to LOAD; counts saturate at INSTR_DEPTH.
// CONFIGURATION
//  SEQ_LOADER_OVF_CHECK_EN defined: a record to a cell whose count == INSTR_DEPTH is dropped
//    (no instr_ld) and err_ovf set sticky until rst.
//  Not defined: no check; record written (sequencer address wraps); err_ovf tied 0.
// STRUCTURE
//  - Shared package: ROWS, COLUMNS, INSTR_WIDTH, INSTR_DEPTH, typedef LoadRecord
//    {row,col,instr,last}, enum LoaderState {IDLE,LOAD,FLUSH,DONE}.
//  - Sub-module seq_cell_counter_bank: ROWS*COLUMNS counters, clear/inc/full per cell.
// TESTING
//  - 3 records (0,0),(0,1),(1,7), last on 3rd, in_valid continuous -> instr_ld high 3
//    consecutive cycles; rb/cb one-hot match; done pulses 2 cycles after last accept.
//  - in_valid toggled 1/0 over 4 records -> instr_ld has gaps matching valid; words in order.
//  - Record row=2 (ROWS=2) mid-stream -> no strobe for it; err_addr=1 and stays set;
//    remaining records loaded.
//  - 65 records to cell (1,3) with macro -> 64 strobes, err_ovf=1 on the 65th; without
//    macro -> 65 strobes, err_ovf=0.
//  - rst asserted 1 cycle after 2nd accept -> next cycle all outputs 0, state IDLE,
//    no done pulse.
//  - start pulsed during LOAD -> ignored; session completes normally with a single done.

Source files
------------

// File: rtl/seq_instr_loader_pkg.sv
// Shared types and constants for the sequencer instruction loader.
// Row/column select fields carry one spare bit so that out-of-range targets can be
// presented by the program source and flagged rather than silently aliased.
package seq_instr_loader_pkg;

  localparam int unsigned Rows       = 2;
  localparam int unsigned Columns    = 8;
  localparam int unsigned InstrWidth = 27;
  localparam int unsigned InstrDepth = 64;

  localparam int unsigned RowW  = $clog2(Rows) + 1;
  localparam int unsigned ColW  = $clog2(Columns) + 1;
  localparam int unsigned Cells = Rows * Columns;
  localparam int unsigned CellW = $clog2(Cells);
  localparam int unsigned CntW  = $clog2(InstrDepth) + 1;

  typedef struct packed {
    logic [RowW-1:0]       row;
    logic [ColW-1:0]       col;
    logic [InstrWidth-1:0] instr;
    logic                  last;
  } load_record_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone
  } loader_state_e;

  // True when the record targets an existing cell.
  function automatic logic in_range(input logic [RowW-1:0] row, input logic [ColW-1:0] col);
    return (32'(row) < Rows) && (32'(col) < Columns);
  endfunction

  // Flat row-major cell index; only meaningful for in-range targets.
  function automatic logic [CellW-1:0] cell_index(input logic [RowW-1:0] row,
                                                  input logic [ColW-1:0] col);
    return CellW'(32'(row) * Columns + 32'(col));
  endfunction

endpackage

// File: rtl/seq_instr_loader_cell_counter_bank.sv
// Per-cell instruction counters, one per sequencer. Cleared together at session start,
// incremented for the selected cell, saturating at the instruction memory depth.
module seq_cell_counter_bank
  import seq_instr_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CellW-1:0] idx,
  output logic             full
);

  logic [CntW-1:0] cnt_q [Cells];

  assign full = (cnt_q[idx] == CntW'(InstrDepth));

  // Counter storage: clear wins over increment; a full cell holds its count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < Cells; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc && !full) begin
      cnt_q[idx] <= cnt_q[idx] + CntW'(1);
    end
  end

endmodule

// File: rtl/seq_instr_loader.sv
// Streams {row, col, instr} records into the DRRA sequencer instruction memories.
// Optional feature: define SEQ_LOADER_OVF_CHECK_EN to drop records aimed at a cell that
// already holds InstrDepth instructions and raise sticky err_ovf; otherwise such records
// are written (sequencer address wraps) and err_ovf is tied low.
module seq_instr_loader
  import seq_instr_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RowW-1:0]       in_row,
  input  logic [ColW-1:0]       in_col,
  input  logic [InstrWidth-1:0] in_instr,
  input  logic                  in_last,
  output logic                  instr_ld,
  output logic [InstrWidth-1:0] instr_inp,
  output logic [Rows-1:0]       seq_address_rb,
  output logic [Columns-1:0]    seq_address_cb,
  output logic                  done,
  output logic                  err_addr,
  output logic                  err_ovf
);

  load_record_t          rec;
  loader_state_e         state_q, state_d;
  logic                  accept;
  logic                  rec_in_range;
  logic                  ovf_drop;
  logic                  emit;
  logic                  cnt_clr;
  logic                  cell_full;
  logic [CellW-1:0]      cell_idx;

  logic                  instr_ld_q;
  logic [InstrWidth-1:0] instr_inp_q;
  logic [Rows-1:0]       rb_q;
  logic [Columns-1:0]    cb_q;
  logic                  err_addr_q;

  assign rec = '{row: in_row, col: in_col, instr: in_instr, last: in_last};

  assign in_ready     = (state_q == StLoad);
  assign accept       = in_valid & in_ready;
  assign rec_in_range = in_range(rec.row, rec.col);
  // Out-of-range targets never reach the counter bank.
  assign cell_idx     = rec_in_range ? cell_index(rec.row, rec.col) : '0;

`ifdef SEQ_LOADER_OVF_CHECK_EN
  logic err_ovf_q;

  assign ovf_drop = cell_full;
  assign err_ovf  = err_ovf_q;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
    end else if (accept && rec_in_range && cell_full) begin
      err_ovf_q <= 1'b1;
    end
  end
`else
  logic unused_cell_full;

  assign unused_cell_full = cell_full;
  assign ovf_drop         = 1'b0;
  assign err_ovf          = 1'b0;
`endif

  assign emit = accept & rec_in_range & ~ovf_drop;

  seq_cell_counter_bank u_counters (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (emit),
    .idx  (cell_idx),
    .full (cell_full)
  );

  // Next-state logic; counters are cleared on the transition into LOAD.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_clr = 1'b1;
        end
      end
      StLoad:  if (accept && rec.last) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and registered write port; selects are zero whenever no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      instr_ld_q  <= 1'b0;
      instr_inp_q <= '0;
      rb_q        <= '0;
      cb_q        <= '0;
      err_addr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_ld_q  <= emit;
      instr_inp_q <= emit ? rec.instr : '0;
      rb_q        <= emit ? (Rows'(1) << rec.row) : '0;
      cb_q        <= emit ? (Columns'(1) << rec.col) : '0;
      err_addr_q  <= err_addr_q | (accept & ~rec_in_range);
    end
  end

  assign instr_ld       = instr_ld_q;
  assign instr_inp      = instr_inp_q;
  assign seq_address_rb = rb_q;
  assign seq_address_cb = cb_q;
  assign done           = (state_q == StDone);
  assign err_addr       = err_addr_q;

endmodule
